cp_rf_write_arbiter: RTL and testbench
======================================

// Module: cp_rf_write_arbiter
// PURPOSE
//  Shares the CP register file's single write port among three sources: pipeline WB (highest
//  priority), returns from long-latency units buffered in a small FIFO, and debug-host writes
//  (lowest). Keeps a per-register pending scoreboard that ID uses for hazard checks, and
//  requests a WB stall when buffered returns are starved. Sits between WB/LL units and cp_rf.
// PARAMETERS
//  DATA_WIDTH   32  RF data width
//  INDEX_WIDTH  5   RF address width
//  RF_DEPTH     28  valid registers 1..RF_DEPTH-1; r0 reads as zero and is never written
//  FIFO_DEPTH   4   long-latency return buffer entries (power of 2)
//  STARVE_LIMIT 8   cycles the FIFO head may be blocked by WB before a stall is requested
// PORTS
//  iClk              in   1    system clock, posedge
//  iReset_n          in   1    asynchronous reset, active low
//  iWB_Write_Enable  in   1    WB write request
//  iWB_Write_Addr    in   IW   WB write address
//  iWB_Write_Data    in   DW   WB write data
//  iLL_Issue         in   1    long-latency op issued; marks its destination pending
//  iLL_Issue_Addr    in   IW   destination of issued op
//  iLL_Valid         in   1    long-latency result valid
//  iLL_Addr          in   IW   result destination
//  iLL_Data          in   DW   result data
//  oLL_Ready         out  1    FIFO can accept (= not full)
//  iHost_Valid       in   1    debug write request
//  iHost_Addr        in   IW   debug write address
//  iHost_Data        in   DW   debug write data
//  oHost_Ready       out  1    debug write accepted this cycle
//  iRd_Addr_A/B      in   IW   ID read addresses
//  oPending_A/B      out  1    addressed register awaits a long-latency result
//  oRF_Write_Enable  out  1    to cp_rf write enable
//  oRF_Write_Addr    out  IW   to cp_rf write address
//  oRF_Write_Data    out  DW   to cp_rf write data
//  oStall_WB         out  1    registered: pipeline must hold WB next cycle
//  oFifo_Count       out  log2(FIFO_DEPTH)+1  current FIFO occupancy
//  oProto_Err        out  1    sticky: WB write while oStall_WB=1
// BEHAVIOUR
//  Reset: FIFO empty, scoreboard clear, state NORMAL, wait counter 0; oStall_WB=0,
//   oProto_Err=0, oFifo_Count=0, oLL_Ready=1; RF write outputs 0 while no source is granted.
//  Grant (combinational, same cycle, zero latency): WB if iWB_Write_Enable; else FIFO head if
//   not empty; else host if iHost_Valid. oHost_Ready=1 only when host granted.
//  Address filter: granted write with addr 0 or >= RF_DEPTH drives oRF_Write_Enable=0; the
//   transaction is still consumed (FIFO popped / host acked). Address and data still driven.
//  FIFO: push when iLL_Valid & oLL_Ready; pop when head granted. Full: oLL_Ready=0 even if a
//   pop occurs this cycle (no push-on-pop-when-full). Pointers wrap modulo FIFO_DEPTH.
//  Scoreboard: bit set on iLL_Issue (valid addr only); cleared when a FIFO entry for that
//   addr is granted. Same-cycle set and clear of same addr: set wins. WB writes never clear.
//   oPending_A/B = bit[iRd_Addr]; 0 for addr 0 or out of range. No bypass of clear.
//  Starvation FSM: NORMAL: counter increments each cycle FIFO non-empty and WB granted,
//   resets to 0 when head granted or FIFO empty; when counter reaches STARVE_LIMIT-1 and head
//   is blocked again -> DRAIN. DRAIN: oStall_WB=1 (registered, from next cycle); leave to
//   NORMAL on the cycle FIFO becomes empty (oStall_WB=0 next cycle), counter cleared.
//   WB still wins if enabled during DRAIN; oProto_Err set and held until reset.
//  Reset mid-operation: FIFO contents and pending bits discarded, all outputs to reset values.
// TESTING
//  1 Reset, WB writes r5=0xDEAD -> same cycle oRF_Write_Enable=1, addr 5, data 0xDEAD.
//  2 Issue r7, LL returns r7=0x11 while WB writes r3 -> r3 written, oPending for r7 stays 1;
//    next idle cycle r7=0x11 written, oPending r7 -> 0 next cycle, oFifo_Count 1->0.
//  3 Push 4 LL returns with WB busy -> oLL_Ready=0 at count 4; 5th iLL_Valid held, not lost.
//  4 WB busy 8 consecutive cycles with FIFO non-empty -> oStall_WB=1; WB idle -> FIFO drains,
//    oStall_WB=0 cycle after empty; WB write during stall -> oProto_Err=1 sticky.
//  5 Host write r0 and r30 -> oHost_Ready=1, oRF_Write_Enable=0; host r9 blocked by FIFO
//    entry until FIFO empty.
//  6 iLL_Issue r4 same cycle FIFO grants r4 -> r4 written, oPending r4 remains 1.

Source files
------------

// File: rtl/cp_rf_write_arbiter.sv
// cp_rf_write_arbiter
// Shares the CP register file's single write port among three sources, in
// priority order: pipeline WB, buffered long-latency (LL) returns, and
// debug-host writes. Tracks which registers still await an LL result so ID
// can detect hazards. Requests a WB stall when buffered returns are starved.
//
// Ports
//   iClk, iReset_n                       clock (posedge), async active-low reset
//   iWB_Write_Enable/Addr/Data           WB write request (always wins)
//   iLL_Issue, iLL_Issue_Addr            LL op issued, destination marked pending
//   iLL_Valid/Addr/Data, oLL_Ready       LL result into the return FIFO
//   iHost_Valid/Addr/Data, oHost_Ready   debug-host write, acked when granted
//   iRd_Addr_A/B, oPending_A/B           scoreboard lookups for ID
//   oRF_Write_Enable/Addr/Data           write port toward cp_rf
//   oStall_WB                            registered stall request while draining
//   oFifo_Count                          return FIFO occupancy
//   oProto_Err                           sticky: WB wrote while stalled
module cp_rf_write_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int INDEX_WIDTH  = 5,
   parameter int RF_DEPTH     = 28,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          iClk,
   input  logic                          iReset_n,
   input  logic                          iWB_Write_Enable,
   input  logic [INDEX_WIDTH-1:0]        iWB_Write_Addr,
   input  logic [DATA_WIDTH-1:0]         iWB_Write_Data,
   input  logic                          iLL_Issue,
   input  logic [INDEX_WIDTH-1:0]        iLL_Issue_Addr,
   input  logic                          iLL_Valid,
   input  logic [INDEX_WIDTH-1:0]        iLL_Addr,
   input  logic [DATA_WIDTH-1:0]         iLL_Data,
   output logic                          oLL_Ready,
   input  logic                          iHost_Valid,
   input  logic [INDEX_WIDTH-1:0]        iHost_Addr,
   input  logic [DATA_WIDTH-1:0]         iHost_Data,
   output logic                          oHost_Ready,
   input  logic [INDEX_WIDTH-1:0]        iRd_Addr_A,
   input  logic [INDEX_WIDTH-1:0]        iRd_Addr_B,
   output logic                          oPending_A,
   output logic                          oPending_B,
   output logic                          oRF_Write_Enable,
   output logic [INDEX_WIDTH-1:0]        oRF_Write_Addr,
   output logic [DATA_WIDTH-1:0]         oRF_Write_Data,
   output logic                          oStall_WB,
   output logic [$clog2(FIFO_DEPTH):0]   oFifo_Count,
   output logic                          oProto_Err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {ST_NORMAL = 1'b0, ST_DRAIN = 1'b1} state_t;

   // r0 is hard-wired zero and indices at or above RF_DEPTH do not exist.
   function automatic logic addr_ok(input logic [INDEX_WIDTH-1:0] a);
      return (a != '0) && (int'(a) < RF_DEPTH);
   endfunction

   logic [INDEX_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [RF_DEPTH-1:0]    pend_q, pend_d;
   logic [SW-1:0]          starve_q, starve_d;
   state_t                 state_q, state_d;
   logic                   perr_q, perr_d;

   logic                   fifo_empty, fifo_full, push, pop;
   logic                   wb_gnt, fifo_gnt, host_gnt;
   logic [INDEX_WIDTH-1:0] head_addr, gnt_addr;
   logic [DATA_WIDTH-1:0]  gnt_data;

   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
   // Full blocks a push even when the head is popped the same cycle.
   assign push       = iLL_Valid && !fifo_full;
   assign pop        = fifo_gnt;

   always_comb begin
      wb_gnt   = iWB_Write_Enable;
      fifo_gnt = !iWB_Write_Enable && !fifo_empty;
      host_gnt = !iWB_Write_Enable && fifo_empty && iHost_Valid;
      gnt_addr = '0;
      gnt_data = '0;
      if (wb_gnt) begin
         gnt_addr = iWB_Write_Addr;
         gnt_data = iWB_Write_Data;
      end else if (fifo_gnt) begin
         gnt_addr = head_addr;
         gnt_data = fifo_data_q[rd_ptr_q];
      end else if (host_gnt) begin
         gnt_addr = iHost_Addr;
         gnt_data = iHost_Data;
      end
   end

   // A granted write to a nonexistent register is still consumed, only the
   // enable is suppressed.
   assign oRF_Write_Enable = (wb_gnt || fifo_gnt || host_gnt) && addr_ok(gnt_addr);
   assign oRF_Write_Addr   = gnt_addr;
   assign oRF_Write_Data   = gnt_data;
   assign oHost_Ready      = host_gnt;
   assign oLL_Ready        = !fifo_full;
   assign oFifo_Count      = cnt_q;
   assign oStall_WB        = (state_q == ST_DRAIN);
   assign oProto_Err       = perr_q;
   assign oPending_A       = addr_ok(iRd_Addr_A) && pend_q[iRd_Addr_A];
   assign oPending_B       = addr_ok(iRd_Addr_B) && pend_q[iRd_Addr_B];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
   end

   // Clear before set so a same-cycle issue to the drained register wins.
   always_comb begin
      pend_d = pend_q;
      if (fifo_gnt && addr_ok(head_addr))
         pend_d[head_addr] = 1'b0;
      if (iLL_Issue && addr_ok(iLL_Issue_Addr))
         pend_d[iLL_Issue_Addr] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      perr_d   = perr_q || (iWB_Write_Enable && oStall_WB);
      case (state_q)
         ST_NORMAL: begin
            if (!fifo_empty && wb_gnt) begin
               if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                  state_d  = ST_DRAIN;
                  starve_d = '0;
               end else begin
                  starve_d = starve_q + 1'b1;
               end
            end else begin
               starve_d = '0;
            end
         end
         ST_DRAIN: begin
            starve_d = '0;
            if (cnt_d == '0) state_d = ST_NORMAL;
         end
         default: begin
            state_d  = ST_NORMAL;
            starve_d = '0;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         pend_q   <= '0;
         starve_q <= '0;
         state_q  <= ST_NORMAL;
         perr_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         starve_q <= starve_d;
         state_q  <= state_d;
         perr_q   <= perr_d;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge iClk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= iLL_Addr;
         fifo_data_q[wr_ptr_q] <= iLL_Data;
      end
   end

endmodule

// File: tb/tb_cp_rf_write_arbiter.sv
module tb_cp_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_en, iss, ll_v, host_v;
   logic [4:0]  wb_a, iss_a, ll_a, host_a, rd_a, rd_b;
   logic [31:0] wb_d, ll_d, host_d;
   logic        ll_rdy, host_rdy, pend_a, pend_b, rf_we, stall, perr;
   logic [4:0]  rf_a;
   logic [31:0] rf_d;
   logic [2:0]  fcnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cp_rf_write_arbiter dut (
      .iClk(clk), .iReset_n(rst_n),
      .iWB_Write_Enable(wb_en), .iWB_Write_Addr(wb_a), .iWB_Write_Data(wb_d),
      .iLL_Issue(iss), .iLL_Issue_Addr(iss_a),
      .iLL_Valid(ll_v), .iLL_Addr(ll_a), .iLL_Data(ll_d), .oLL_Ready(ll_rdy),
      .iHost_Valid(host_v), .iHost_Addr(host_a), .iHost_Data(host_d), .oHost_Ready(host_rdy),
      .iRd_Addr_A(rd_a), .iRd_Addr_B(rd_b), .oPending_A(pend_a), .oPending_B(pend_b),
      .oRF_Write_Enable(rf_we), .oRF_Write_Addr(rf_a), .oRF_Write_Data(rf_d),
      .oStall_WB(stall), .oFifo_Count(fcnt), .oProto_Err(perr)
   );

   // Inputs for one cycle followed by every output expected during that cycle.
   typedef struct {
      int unsigned wb, wa, wd, is, ia, lv, la, ld, hv, ha, hd, ra, rb;
      int unsigned we, ea, ed, lr, hr, pa, pb, st, cn, pe;
   } vec_t;

   localparam int NV = 30;
   vec_t tbl [NV];

   task automatic chk(input string tag, input string name, input logic [31:0] act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s actual=%0h expected=%0h", tag, name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input logic rst_val, input string tag);
      @(negedge clk);
      rst_n  = rst_val;
      wb_en  = 1'(v.wb); wb_a = 5'(v.wa); wb_d = v.wd;
      iss    = 1'(v.is); iss_a = 5'(v.ia);
      ll_v   = 1'(v.lv); ll_a = 5'(v.la); ll_d = v.ld;
      host_v = 1'(v.hv); host_a = 5'(v.ha); host_d = v.hd;
      rd_a   = 5'(v.ra); rd_b = 5'(v.rb);
      #1;
      chk(tag, "rf_we",    32'(rf_we),    v.we);
      chk(tag, "rf_addr",  32'(rf_a),     v.ea);
      chk(tag, "rf_data",  rf_d,          v.ed);
      chk(tag, "ll_ready", 32'(ll_rdy),   v.lr);
      chk(tag, "host_rdy", 32'(host_rdy), v.hr);
      chk(tag, "pend_a",   32'(pend_a),   v.pa);
      chk(tag, "pend_b",   32'(pend_b),   v.pb);
      chk(tag, "stall",    32'(stall),    v.st);
      chk(tag, "count",    32'(fcnt),     v.cn);
      chk(tag, "proto",    32'(perr),     v.pe);
   endtask

   initial begin
      vec_t s;
      //             wb wa  wd        is ia lv la  ld     hv ha  hd    ra  rb  | we ea  ed      lr hr pa pb st cn pe
      tbl[0]  = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    0,  0,   0, 0,  0,      1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 5, 'hDEAD,   0, 0, 0, 0,  0,     0, 0,  0,    0,  0,   1, 5,  'hDEAD, 1, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0,        1, 7, 0, 0,  0,     0, 0,  0,    7,  0,   0, 0,  0,      1, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 3, 'h33,     0, 0, 1, 7,  'h11,  0, 0,  0,    7,  3,   1, 3,  'h33,   1, 0, 1, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    7,  3,   1, 7,  'h11,   1, 0, 1, 0, 0, 1, 0};
      tbl[5]  = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    7,  3,   0, 0,  0,      1, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 0, 0,        1, 4, 0, 0,  0,     0, 0,  0,    4,  0,   0, 0,  0,      1, 0, 0, 0, 0, 0, 0};
      tbl[7]  = '{0, 0, 0,        0, 0, 1, 4,  'h44,  0, 0,  0,    4,  0,   0, 0,  0,      1, 0, 1, 0, 0, 0, 0};
      tbl[8]  = '{0, 0, 0,        1, 4, 0, 0,  0,     0, 0,  0,    4,  0,   1, 4,  'h44,   1, 0, 1, 0, 0, 1, 0};
      tbl[9]  = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    4,  7,   0, 0,  0,      1, 0, 1, 0, 0, 0, 0};
      tbl[10] = '{0, 0, 0,        0, 0, 0, 0,  0,     1, 0,  1,    0,  0,   0, 0,  1,      1, 1, 0, 0, 0, 0, 0};
      tbl[11] = '{0, 0, 0,        0, 0, 0, 0,  0,     1, 30, 2,    30, 31,  0, 30, 2,      1, 1, 0, 0, 0, 0, 0};
      tbl[12] = '{1, 1, 1,        0, 0, 1, 9,  'h99,  0, 0,  0,    0,  0,   1, 1,  1,      1, 0, 0, 0, 0, 0, 0};
      tbl[13] = '{0, 0, 0,        0, 0, 0, 0,  0,     1, 9,  'hAA, 0,  0,   1, 9,  'h99,   1, 0, 0, 0, 0, 1, 0};
      tbl[14] = '{0, 0, 0,        0, 0, 0, 0,  0,     1, 9,  'hAA, 0,  0,   1, 9,  'hAA,   1, 1, 0, 0, 0, 0, 0};
      tbl[15] = '{0, 0, 0,        0, 0, 1, 0,  5,     0, 0,  0,    0,  0,   0, 0,  0,      1, 0, 0, 0, 0, 0, 0};
      tbl[16] = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    0,  0,   0, 0,  5,      1, 0, 0, 0, 0, 1, 0};
      tbl[17] = '{0, 0, 0,        0, 0, 0, 0,  0,     1, 27, 7,    0,  0,   1, 27, 7,      1, 1, 0, 0, 0, 0, 0};
      tbl[18] = '{0, 0, 0,        0, 0, 0, 0,  0,     1, 28, 8,    0,  0,   0, 28, 8,      1, 1, 0, 0, 0, 0, 0};
      tbl[19] = '{1, 2, 0,        0, 0, 1, 10, 'hA0,  0, 0,  0,    0,  0,   1, 2,  0,      1, 0, 0, 0, 0, 0, 0};
      tbl[20] = '{1, 2, 1,        0, 0, 1, 11, 'hA1,  0, 0,  0,    0,  0,   1, 2,  1,      1, 0, 0, 0, 0, 1, 0};
      tbl[21] = '{1, 2, 2,        0, 0, 1, 12, 'hA2,  0, 0,  0,    0,  0,   1, 2,  2,      1, 0, 0, 0, 0, 2, 0};
      tbl[22] = '{1, 2, 3,        0, 0, 1, 13, 'hA3,  0, 0,  0,    0,  0,   1, 2,  3,      1, 0, 0, 0, 0, 3, 0};
      tbl[23] = '{1, 2, 4,        0, 0, 1, 14, 'hA4,  0, 0,  0,    0,  0,   1, 2,  4,      0, 0, 0, 0, 0, 4, 0};
      tbl[24] = '{0, 0, 0,        0, 0, 1, 14, 'hA4,  0, 0,  0,    0,  0,   1, 10, 'hA0,   0, 0, 0, 0, 0, 4, 0};
      tbl[25] = '{0, 0, 0,        0, 0, 1, 14, 'hA4,  0, 0,  0,    0,  0,   1, 11, 'hA1,   1, 0, 0, 0, 0, 3, 0};
      tbl[26] = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    0,  0,   1, 12, 'hA2,   1, 0, 0, 0, 0, 3, 0};
      tbl[27] = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    0,  0,   1, 13, 'hA3,   1, 0, 0, 0, 0, 2, 0};
      tbl[28] = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    0,  0,   1, 14, 'hA4,   1, 0, 0, 0, 0, 1, 0};
      tbl[29] = '{0, 0, 0,        0, 0, 0, 0,  0,     0, 0,  0,    0,  0,   0, 0,  0,      1, 0, 0, 0, 0, 0, 0};

      wb_en = 0; wb_a = 0; wb_d = 0; iss = 0; iss_a = 0;
      ll_v = 0; ll_a = 0; ll_d = 0; host_v = 0; host_a = 0; host_d = 0;
      rd_a = 0; rd_b = 0;
      repeat (3) @(posedge clk);

      for (int i = 0; i < NV; i++)
         apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // Starvation: one buffered return, then WB holds the port.
      s = '{default: 0};
      s.wb = 1; s.wa = 2; s.wd = 'h100; s.lv = 1; s.la = 12; s.ld = 'h55;
      s.we = 1; s.ea = 2; s.ed = 'h100; s.lr = 1;
      apply(s, 1'b1, "starve_push");
      for (int i = 1; i <= 8; i++) begin
         s = '{default: 0};
         s.wb = 1; s.wa = 2; s.wd = 'h100 + i;
         s.we = 1; s.ea = 2; s.ed = 'h100 + i; s.lr = 1; s.cn = 1;
         apply(s, 1'b1, $sformatf("starve_blk%0d", i));
      end
      s = '{default: 0};
      s.wb = 1; s.wa = 2; s.wd = 'h200;
      s.we = 1; s.ea = 2; s.ed = 'h200; s.lr = 1; s.cn = 1; s.st = 1;
      apply(s, 1'b1, "stall_wb_write");
      s = '{default: 0};
      s.we = 1; s.ea = 12; s.ed = 'h55; s.lr = 1; s.cn = 1; s.st = 1; s.pe = 1;
      apply(s, 1'b1, "drain_pop");
      s = '{default: 0};
      s.lr = 1; s.pe = 1;
      apply(s, 1'b1, "drain_done");
      s = '{default: 0};
      s.wb = 1; s.wa = 6; s.wd = 9; s.we = 1; s.ea = 6; s.ed = 9; s.lr = 1; s.pe = 1;
      apply(s, 1'b1, "proto_sticky");

      // Reset in the middle of activity discards FIFO and scoreboard.
      s = '{default: 0};
      s.is = 1; s.ia = 15; s.lv = 1; s.la = 15; s.ld = 1; s.ra = 15;
      s.lr = 1; s.pe = 1;
      apply(s, 1'b1, "pre_rst_push");
      s = '{default: 0};
      s.wb = 1; s.wa = 2; s.wd = 3; s.ra = 15;
      s.we = 1; s.ea = 2; s.ed = 3; s.lr = 1; s.pa = 1; s.cn = 1; s.pe = 1;
      apply(s, 1'b1, "pre_rst_hold");
      s = '{default: 0};
      s.ra = 15; s.lr = 1;
      apply(s, 1'b0, "in_reset");
      apply(s, 1'b1, "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
